test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer_if.sv | 14 +
 rtl/test_sequencer.sv | 124 ++++++++++++
 tb/tb_test_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/test_sequencer_if.sv
// test_sequencer_if: dump-read memory bus plus dump output stream
interface test_sequencer_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  dump_valid;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [DATA_WIDTH-1:0] dump_data;
  modport master (output mem_read, mem_addr, dump_valid, dump_addr, dump_data, input mem_rdata);
  modport slave  (input mem_read, mem_addr, dump_valid, dump_addr, dump_data, output mem_rdata);
endinterface

// File: rtl/test_sequencer.sv
// test_sequencer: per-slot processor reset/run/memory-dump test sequencer
module test_sequencer #(
  parameter int NUM_TESTS   = 8,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int CYC_WIDTH   = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_TESTS-1:0]  test_en,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_idx,
  input  logic [CYC_WIDTH-1:0]  cfg_cycles,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_last,
  output logic                  cpu_rst_n,
  output logic [3:0]            test_idx,
  output logic                  busy,
  output logic                  done,
  test_sequencer_if.master      bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DUMP   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [CYC_WIDTH-1:0] HOLD_LAST = CYC_WIDTH'(HOLD_CYCLES - 1);
  logic [2:0]            state;
  logic [4:0]            idx;
  logic [15:0]           en;
  logic [CYC_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] addr, daddr;
  logic                  dval;
  logic [CYC_WIDTH-1:0]  cyc_m  [16];
  logic [ADDR_WIDTH-1:0] base_m [16];
  logic [ADDR_WIDTH-1:0] last_m [16];
  logic [CYC_WIDTH-1:0]  cur_cyc;
  logic [ADDR_WIDTH-1:0] cur_base, cur_last;
  assign cur_cyc  = cyc_m[idx[3:0]];
  assign cur_base = base_m[idx[3:0]];
  assign cur_last = last_m[idx[3:0]];
  // idx is one bit wider than test_idx so running past slot 15 never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      en    <= '0;
      cnt   <= '0;
      addr  <= '0;
      daddr <= '0;
      dval  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      dval  <= 1'b0;
    end else begin
      dval <= state == S_DUMP;
      if (state == S_DUMP) daddr <= addr;
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            en    <= 16'(test_en);
            idx   <= '0;
            state <= S_SELECT;
          end
        S_SELECT:
          if (idx >= 5'(NUM_TESTS)) state <= S_DONE;
          else if (en[idx[3:0]]) begin
            state <= S_HOLD;
            cnt   <= '0;
          end else idx <= idx + 5'd1;
        S_HOLD:
          if (cnt == HOLD_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
          end else cnt <= cnt + CYC_WIDTH'(1);
        S_RUN:
          if (cur_cyc == '0 || cnt == cur_cyc - CYC_WIDTH'(1)) begin
            if (cur_base > cur_last) begin
              idx   <= idx + 5'd1;
              state <= S_SELECT;
            end else begin
              addr  <= cur_base;
              state <= S_DUMP;
            end
          end else cnt <= cnt + CYC_WIDTH'(1);
        S_DUMP:
          if (addr == cur_last) state <= S_DRAIN;
          else addr <= addr + ADDR_WIDTH'(1);
        S_DRAIN: begin
          idx   <= idx + 5'd1;
          state <= S_SELECT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        cyc_m[i]  <= '0;
        base_m[i] <= ADDR_WIDTH'(1);
        last_m[i] <= '0;
      end
    end else if (cfg_we && !busy && {1'b0, cfg_idx} < 5'(NUM_TESTS)) begin
      cyc_m[cfg_idx]  <= cfg_cycles;
      base_m[cfg_idx] <= cfg_base;
      last_m[cfg_idx] <= cfg_last;
    end
  end
  assign cpu_rst_n      = state == S_RUN && cur_cyc != '0;
  assign busy           = state >= S_SELECT && state <= S_DRAIN;
  assign done           = state == S_DONE;
  assign test_idx       = idx[3:0];
  assign bus.mem_read   = state == S_DUMP;
  assign bus.mem_addr   = addr;
  assign bus.dump_valid = dval;
  assign bus.dump_addr  = daddr;
  assign bus.dump_data  = dval ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: randomized scoreboard bench against an event-list model of the sequencer
module tb_test_sequencer;
  localparam int N = 8, AW = 26, DW = 32, CW = 16, HC = 2;
  logic clk = 0, rst = 1, start = 0, abort = 0, cfg_we = 0;
  logic [N-1:0] test_en = '0;
  logic [3:0] cfg_idx = '0;
  logic [CW-1:0] cfg_cycles = '0;
  logic [AW-1:0] cfg_base = '0, cfg_last = '0;
  logic cpu_rst_n, busy, done;
  logic [3:0] test_idx;
  test_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  test_sequencer #(.NUM_TESTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CYC_WIDTH(CW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .test_en(test_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycles(cfg_cycles), .cfg_base(cfg_base), .cfg_last(cfg_last),
    .cpu_rst_n(cpu_rst_n), .test_idx(test_idx), .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] h(input logic [AW-1:0] a);
    return {a[5:0], a} ^ 32'h5A5A1234;
  endfunction
  // memory returns data exactly one cycle after a read, garbage otherwise
  always @(posedge clk) bus.mem_rdata <= bus.mem_read ? h(bus.mem_addr) : 32'hDEADBEEF;
  typedef struct {int kind; longint a; longint b;} ev_t;
  ev_t q[$];
  int errors = 0, checks = 0;
  int m_cyc [N];
  longint m_base [N], m_last [N];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic pop_cmp(input int k, input logic [63:0] a, input logic [63:0] b);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d a=%0h b=%0h, expected none", k, a, b);
    end else begin
      e = q.pop_front();
      chk("event_kind", k, e.kind);
      chk(k != 0 ? "dump_addr" : "run_slot", a, e.a);
      chk(k != 0 ? "dump_data" : "run_len", b, e.b);
    end
  endtask
  logic prev = 0;
  int hi = 0, ridx = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev = 0;
      hi = 0;
    end else begin
      if (cpu_rst_n && !prev) ridx = test_idx;
      if (cpu_rst_n) hi++;
      else if (prev) begin
        pop_cmp(0, ridx, hi);
        hi = 0;
      end
      prev = cpu_rst_n;
      if (bus.dump_valid) pop_cmp(1, bus.dump_addr, bus.dump_data);
    end
  end
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cyc[i] = 0;
      m_base[i] = 1;
      m_last[i] = 0;
    end
  endtask
  task automatic cfg(input int s, input int c, input longint b, input longint l, input bit apply);
    @(posedge clk) #1;
    cfg_we = 1; cfg_idx = s[3:0]; cfg_cycles = c[CW-1:0]; cfg_base = b[AW-1:0]; cfg_last = l[AW-1:0];
    @(posedge clk) #1;
    cfg_we = 0;
    if (apply && s < N) begin
      m_cyc[s] = c;
      m_base[s] = cfg_base;
      m_last[s] = cfg_last;
    end
  endtask
  task automatic expect_seq(input logic [N-1:0] en);
    for (int s = 0; s < N; s++)
      if (en[s]) begin
        if (m_cyc[s] > 0) q.push_back('{0, s, m_cyc[s]});
        for (longint a = m_base[s]; a <= m_last[s]; a++) q.push_back('{1, a, h(a[AW-1:0])});
      end
  endtask
  task automatic pulse_start(input logic [N-1:0] en);
    @(posedge clk) #1;
    test_en = en; start = 1;
    @(posedge clk) #1;
    start = 0;
  endtask
  task automatic wait_done(output int pre);
    int n = 0;
    bit rose = 0;
    pre = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
      if (!rose) begin
        if (cpu_rst_n) rose = 1;
        else if (busy) pre++;
      end
    end
    chk("done_reached", done, 1);
    chk("queue_drained", q.size(), 0);
    chk("done_cpu_rst_n", cpu_rst_n, 0);
  endtask
  task automatic run_seq(input logic [N-1:0] en, output int pre);
    expect_seq(en);
    pulse_start(en);
    wait_done(pre);
  endtask
  task automatic wait_high();
    int n = 0;
    while (!cpu_rst_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("run_entered", cpu_rst_n, 1);
  endtask
  task automatic do_reset();
    @(posedge clk) #1 rst = 1;
    @(posedge clk) #1 rst = 0;
    q.delete();
    model_reset();
    @(negedge clk);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_dump_valid", bus.dump_valid, 0);
    chk("rst_dump_addr", bus.dump_addr, 0);
    chk("rst_dump_data", bus.dump_data, 0);
    chk("rst_test_idx", test_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask
  initial begin
    int pre, r, n;
    longint b, l;
    do_reset();
    run_seq(8'hFF, pre);
    cfg(0, 10, 26'h1000000, 26'h100000F, 1);
    run_seq(8'h01, pre);
    chk("hold_len", pre, 1 + HC);
    for (int s = 0; s < 5; s++) cfg(s, 3 + s, 16 * s, 16 * s + 1, 1);
    run_seq(8'b10100, pre);
    cfg(0, 2, 5, 4, 1);
    cfg(1, 0, 26'h3FFFFFF, 26'h3FFFFFF, 1);
    run_seq(8'h03, pre);
    repeat (6) begin
      for (int s = 0; s < N; s++) begin
        b = longint'($urandom_range(1, 32'h3FFFFF0));
        l = ($urandom_range(0, 3) == 0) ? b - 1 : b + longint'($urandom_range(0, 5));
        cfg(s, $urandom_range(0, 6), b, l, 1);
      end
      cfg(8 + $urandom_range(0, 7), 9, 0, 3, 0);
      run_seq(N'($urandom_range(0, 255)), pre);
    end
    cfg(0, 20, 1, 0, 1);
    expect_seq(8'h01);
    pulse_start(8'h01);
    wait_high();
    cfg(0, 5, 16, 17, 0);
    wait_done(pre);
    cfg(0, 5, 16, 17, 1);
    run_seq(8'h01, pre);
    cfg(0, 2, 5, 4, 1);
    cfg(1, 3, 26'h100, 26'h10F, 1);
    q.push_back('{0, 0, 2});
    q.push_back('{0, 1, 3});
    for (longint a = 26'h100; a < 26'h103; a++) q.push_back('{1, a, h(a[AW-1:0])});
    pulse_start(8'h03);
    r = 0;
    n = 0;
    while (r < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (bus.mem_read) r++;
    end
    chk("reads_before_abort", r, 3);
    @(posedge clk) #1 abort = 1;
    @(posedge clk) #1 abort = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_cpu_rst_n", cpu_rst_n, 0);
    chk("abort_mem_read", bus.mem_read, 0);
    chk("abort_dump_valid", bus.dump_valid, 0);
    chk("abort_done", done, 0);
    repeat (10) @(negedge clk);
    chk("abort_drained", q.size(), 0);
    run_seq(8'h03, pre);
    @(posedge clk) #1;
    start = 1; abort = 1;
    @(posedge clk) #1;
    start = 0; abort = 0;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_done", done, 0);
    cfg(3, 30, 1, 0, 1);
    expect_seq(8'h08);
    pulse_start(8'h08);
    wait_high();
    do_reset();
    run_seq(8'hFF, pre);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
